// File: rtl/oled_pkg.sv
// Shared SSD1306 constants and sequencer state encoding; no logic, no latency.
// Reused by the pixel-data writer, which also drives the SPI byte transmitter.
package oled_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RST_LO = 3'd1,
        ST_WAKE   = 3'd2,
        ST_FETCH  = 3'd3,
        ST_LATCH  = 3'd4,
        ST_SHIFT  = 3'd5,
        ST_GAP    = 3'd6,
        ST_DONE   = 3'd7
    } state_t;

    localparam logic DC_CMD        = 1'b0;
    localparam logic DC_DATA       = 1'b1;
    localparam logic SPI_IDLE_SCLK = 1'b0;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/oled_spi_byte_tx.sv
// SPI mode-0 byte shifter, MSB first: 16*CLK_DIV clk per byte after load, no backpressure.
// byte_done is high in the cycle whose closing edge makes the 8th falling SCLK edge.
module oled_spi_byte_tx
    import oled_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       sclk,
    output logic       sdin,
    output logic       byte_done
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic          active;
    logic [DW-1:0] div_cnt;
    logic [2:0]    bit_cnt;
    logic [6:0]    rest;
    logic          half_end;

    assign half_end  = active && (div_cnt == DIV_LAST);
    assign byte_done = half_end && sclk && (bit_cnt == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active  <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            rest    <= '0;
            sclk    <= SPI_IDLE_SCLK;
            sdin    <= 1'b0;
        end else if (load) begin
            active  <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            rest    <= data[6:0];
            sclk    <= SPI_IDLE_SCLK;
            sdin    <= data[7];
        end else if (active) begin
            if (half_end) begin
                div_cnt <= '0;
                if (!sclk) begin
                    sclk <= 1'b1;
                end else begin
                    // Data only moves on the falling edge so it is stable across the next rise.
                    sclk <= 1'b0;
                    if (bit_cnt == 3'd7) begin
                        active <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        sdin    <= rest[6];
                        rest    <= {rest[5:0], 1'b0};
                    end
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/oled_init_seq.sv
// OLED init sequencer: panel reset, wake delay, then CMD_COUNT RAM bytes over SPI; no backpressure.
// OLED_INIT_START_EN adds a start input; otherwise the sequence runs one cycle after reset release.
module oled_init_seq
    import oled_pkg::*;
#(
    parameter int ADDR_WIDTH  = 5,
    parameter int CMD_COUNT   = 26,
    parameter int CLK_DIV     = 4,
    parameter int RST_CYCLES  = 1000,
    parameter int WAKE_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef OLED_INIT_START_EN
    input  logic                  start,
`endif
    output logic                  cmd_re_n,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_data,
    output logic                  oled_res,
    output logic                  oled_cs_n,
    output logic                  oled_dc,
    output logic                  oled_sclk,
    output logic                  oled_sdin,
    output logic                  busy,
    output logic                  done
);

    localparam int DLY_W = $clog2(max3(RST_CYCLES, WAKE_CYCLES, CLK_DIV) + 1);
    localparam logic [DLY_W-1:0]      RST_LAST  = DLY_W'(RST_CYCLES - 1);
    localparam logic [DLY_W-1:0]      WAKE_LAST = DLY_W'(WAKE_CYCLES - 1);
    localparam logic [DLY_W-1:0]      GAP_LAST  = DLY_W'(CLK_DIV - 1);
    localparam logic [ADDR_WIDTH-1:0] IDX_LAST  = ADDR_WIDTH'(CMD_COUNT - 1);

    state_t                  state, state_nxt;
    logic [DLY_W-1:0]        dly, dly_nxt;
    logic [ADDR_WIDTH-1:0]   idx, idx_nxt;
    logic                    tx_load;
    logic                    tx_done;
    logic                    go;

`ifdef OLED_INIT_START_EN
    assign go = start;
`else
    assign go = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        dly_nxt   = dly;
        idx_nxt   = idx;
        tx_load   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (go) begin
                    state_nxt = ST_RST_LO;
                    dly_nxt   = '0;
                end
            end
            ST_RST_LO: begin
                if (dly == RST_LAST) begin
                    state_nxt = ST_WAKE;
                    dly_nxt   = '0;
                end else begin
                    dly_nxt = dly + 1'b1;
                end
            end
            ST_WAKE: begin
                if (dly == WAKE_LAST) begin
                    state_nxt = ST_FETCH;
                    dly_nxt   = '0;
                    idx_nxt   = '0;
                end else begin
                    dly_nxt = dly + 1'b1;
                end
            end
            ST_FETCH: state_nxt = ST_LATCH;
            ST_LATCH: begin
                tx_load   = 1'b1;
                state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (tx_done) begin
                    state_nxt = ST_GAP;
                    dly_nxt   = '0;
                end
            end
            ST_GAP: begin
                if (dly == GAP_LAST) begin
                    dly_nxt = '0;
                    if (idx == IDX_LAST) begin
                        state_nxt = ST_DONE;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = ST_FETCH;
                    end
                end else begin
                    dly_nxt = dly + 1'b1;
                end
            end
            ST_DONE: state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change cleanly with the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            dly       <= '0;
            idx       <= '0;
            cmd_re_n  <= 1'b1;
            oled_res  <= 1'b0;
            oled_cs_n <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            dly       <= dly_nxt;
            idx       <= idx_nxt;
            cmd_re_n  <= (state_nxt != ST_FETCH);
            oled_res  <= !(state_nxt inside {ST_IDLE, ST_RST_LO});
            oled_cs_n <= !(state_nxt inside {ST_LATCH, ST_SHIFT});
            busy      <= !(state_nxt inside {ST_IDLE, ST_DONE});
            done      <= (state_nxt == ST_DONE);
        end
    end

    assign cmd_addr = idx;
    assign oled_dc  = DC_CMD;

    oled_spi_byte_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (tx_load),
        .data      (cmd_data),
        .sclk      (oled_sclk),
        .sdin      (oled_sdin),
        .byte_done (tx_done)
    );

endmodule

// File: tb/tb_oled_init_seq.sv
// Bench for oled_init_seq: RAM model, SPI decoder/scoreboard, reset-timing and abort checks.
module tb_oled_init_seq;
    import oled_pkg::*;

    localparam int AW    = 5;
    localparam int NCMD  = 26;
    localparam int DIV   = 2;
    localparam int RSTC  = 10;
    localparam int WAKEC = 10;
    localparam int BYTE_CYC = 2 + 16 * DIV + DIV;

    logic          clk;
    logic          rst_n;
    logic          cmd_re_n;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_data;
    logic          oled_res, oled_cs_n, oled_dc, oled_sclk, oled_sdin, busy, done;
`ifdef OLED_INIT_START_EN
    logic          start;
`endif

    oled_init_seq #(
        .ADDR_WIDTH (AW),
        .CMD_COUNT  (NCMD),
        .CLK_DIV    (DIV),
        .RST_CYCLES (RSTC),
        .WAKE_CYCLES(WAKEC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef OLED_INIT_START_EN
        .start     (start),
`endif
        .cmd_re_n  (cmd_re_n),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .oled_res  (oled_res),
        .oled_cs_n (oled_cs_n),
        .oled_dc   (oled_dc),
        .oled_sclk (oled_sclk),
        .oled_sdin (oled_sdin),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [0:(1<<AW)-1];
    always @(posedge clk) cmd_data <= (!cmd_re_n) ? mem[cmd_addr] : 8'h00;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    logic [7:0]    expq [$];
    logic [AW-1:0] addrq [$];
    int   re_cnt = 0;
    int   bytes_seen = 0;

    // SPI/RAM-side monitor: decodes bytes on SCLK rise and scores them at CS release.
    logic       prev_sclk, prev_cs, prev_sdin, dc_bad, sdin_bad;
    logic [7:0] cur;
    int         bitn, cs_cnt;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_sclk = 1'b0; prev_cs = 1'b1; prev_sdin = oled_sdin;
            dc_bad = 1'b0; sdin_bad = 1'b0; bitn = 0; cs_cnt = 0; cur = 8'h00;
        end else begin
            if (!cmd_re_n) begin
                re_cnt++;
                if (addrq.size() == 0) check("extra_ram_read", 1, 0);
                else check("cmd_addr", 32'(cmd_addr), 32'(addrq.pop_front()));
            end
            if (!oled_cs_n) cs_cnt++;
            if (oled_dc !== DC_CMD) dc_bad = 1'b1;
            if (oled_sclk && !prev_sclk) begin
                cur = {cur[6:0], oled_sdin};
                bitn++;
            end
            if (oled_sclk && prev_sclk && (oled_sdin !== prev_sdin)) sdin_bad = 1'b1;
            if (oled_cs_n && !prev_cs) begin
                check("spi_bits", bitn, 8);
                check("cs_low_cycles", cs_cnt, 1 + 16 * DIV);
                check("sdin_stable_high", sdin_bad, 0);
                check("dc_low", dc_bad, 0);
                if (expq.size() == 0) check("spi_byte_extra", 1, 0);
                else check("spi_byte", cur, expq.pop_front());
                bytes_seen++;
                bitn = 0; cs_cnt = 0; sdin_bad = 1'b0; dc_bad = 1'b0;
            end
            prev_sclk = oled_sclk; prev_cs = oled_cs_n; prev_sdin = oled_sdin;
        end
    end

    function automatic logic [13:0] outv();
        return {cmd_re_n, cmd_addr, oled_res, oled_cs_n, oled_dc, oled_sclk, oled_sdin, busy, done};
    endfunction
    localparam logic [13:0] RST_VEC = {1'b1, 5'd0, 1'b0, 1'b1, 5'b00000};

    // Expected traffic: every RAM byte in address order, then fixed timing derived from the parameters.
    task automatic run_seq(input bit abort_byte3, input bit hold_check);
        int n, w, c, k;
        bit flag;
        logic cs_before;
        expq.delete();
        addrq.delete();
        for (int i = 0; i < NCMD; i++) begin
            expq.push_back(mem[i]);
            addrq.push_back(AW'(i));
        end
        re_cnt = 0;
        bytes_seen = 0;
        @(posedge clk); #2 rst_n = 1'b1;
`ifdef OLED_INIT_START_EN
        flag = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (oled_res || busy || !cmd_re_n || !oled_cs_n) flag = 1'b1;
        end
        check("idle_before_start", flag, 0);
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
`else
        @(posedge clk);
`endif
        n = 0;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (oled_res) break;
            n++;
        end
        check("res_low_cycles", n, RSTC);
        w = 0;
        for (k = 0; k < 200; k++) begin
            if (!cmd_re_n) break;
            w++;
            @(negedge clk);
        end
        check("wake_cycles", w, WAKEC);
        check("first_addr", 32'(cmd_addr), 0);
        check("busy_running", {busy, done}, 2'b10);

        if (abort_byte3) begin
            for (k = 0; k < 1000 && bytes_seen < 3; k++) @(negedge clk);
            for (k = 0; k < 20 && oled_cs_n; k++) @(negedge clk);
            repeat ($urandom_range(2, 28)) @(negedge clk);
            cs_before = oled_cs_n;
            check("abort_in_byte3", {32'(bytes_seen), 1'b0}, {32'd3, cs_before});
            #1 rst_n = 1'b0;
            #1 check("reset_mid_byte", outv(), RST_VEC);
            return;
        end

        c = 0;
        while (!done && c < 5000) begin
            @(negedge clk);
            c++;
`ifdef OLED_INIT_START_EN
            if (c == 200) start = 1'b1;
            if (c == 201) start = 1'b0;
`endif
        end
        check("done_latency", c, NCMD * BYTE_CYC);
        check("busy_at_done", busy, 0);
        if (hold_check) begin
            flag = 1'b0;
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                if (!done || busy || !cmd_re_n || oled_sclk || !oled_cs_n) flag = 1'b1;
            end
            check("done_hold", flag, 0);
        end
        check("re_count", re_cnt, NCMD);
        check("bytes_sent", bytes_seen, NCMD);
        check("bytes_pending", expq.size(), 0);
    endtask

    logic [7:0] init_tbl [0:NCMD-1] = '{
        8'hAE, 8'h81, 8'hFF, 8'hA1, 8'hA6, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
        8'h8D, 8'h14, 8'h20, 8'h00, 8'hC8, 8'hDA, 8'h12, 8'hD5, 8'h80, 8'hD9,
        8'hF1, 8'hDB, 8'h40, 8'hA4, 8'h2E, 8'hAF};

    initial begin
        rst_n = 1'b0;
`ifdef OLED_INIT_START_EN
        start = 1'b0;
`endif
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
        for (int i = 0; i < NCMD; i++) mem[i] = init_tbl[i];
        repeat (3) @(negedge clk);
        check("reset_values", outv(), RST_VEC);

        run_seq(1'b0, 1'b1);

        @(negedge clk); #1 rst_n = 1'b0;
        #1 check("reset_after_done", outv(), RST_VEC);

        for (int i = 0; i < NCMD; i++) mem[i] = 8'($urandom);
        run_seq(1'b1, 1'b0);

        repeat (3) @(negedge clk);
        for (int i = 0; i < NCMD; i++) mem[i] = 8'($urandom);
        run_seq(1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
